armleocpu_regfile_wb_ctrl: RTL

Write-back controller for the 32x32 integer register file (x0 hard-wired zero, async-reset to 0, 2 combinational read ports, 1 synchronous write port).
- Arbitrates the single write port among NUM_REQ write-back sources (ALU, LSU, MULDIV) using round-robin and a valid/ready handshake.
- Keeps a 32-entry pending-write scoreboard so decode can stall on RAW and WAW hazards.
- Sits between the execute/memory units and the register file; drives the register file's rd_addr, rd_wdata and rd_write.

---
 rtl/armleocpu_defines.sv | 8 +
 rtl/armleocpu_rr_arbiter.sv | 69 ++++++
 rtl/armleocpu_regfile_wb_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/armleocpu_defines.sv
// Shared register-file geometry for the integer pipeline.
package armleocpu_defines;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam int REG_COUNT  = 32;

endpackage

// File: rtl/armleocpu_rr_arbiter.sv
// Round-robin arbiter: one-hot grant among valid requesters, scan starts at rr_ptr.
// The pointer advances past the winner only when the grant is accepted.
module armleocpu_rr_arbiter #(
    parameter int NUM_REQ = 3,
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic               accept,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic [IDX_W-1:0] rr_ptr_q;
    logic [IDX_W-1:0] rr_ptr_d;
    logic [IDX_W-1:0] next_ptr_s;

    // Winner selection: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        logic             found_s;
        logic [IDX_W:0]   sum_s;
        logic [IDX_W-1:0] cand_s;
        grant     = {NUM_REQ{1'b0}};
        grant_idx = {IDX_W{1'b0}};
        found_s   = 1'b0;
        sum_s     = {(IDX_W+1){1'b0}};
        cand_s    = {IDX_W{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            sum_s = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
            if (sum_s >= (IDX_W+1)'(NUM_REQ)) begin
                cand_s = IDX_W'(sum_s - (IDX_W+1)'(NUM_REQ));
            end else begin
                cand_s = sum_s[IDX_W-1:0];
            end
            if (!found_s && req_valid[cand_s]) begin
                found_s           = 1'b1;
                grant[cand_s]     = 1'b1;
                grant_idx         = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Pointer next-state: one past the accepted winner, otherwise hold.
    always_comb begin
        if (grant_idx == IDX_W'(NUM_REQ - 1)) begin
            next_ptr_s = {IDX_W{1'b0}};
        end else begin
            next_ptr_s = grant_idx + IDX_W'(1);
        end
        if (accept) begin
            rr_ptr_d = next_ptr_s;
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= {IDX_W{1'b0}};
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/armleocpu_regfile_wb_ctrl.sv
// Register-file write-back controller: round-robin write-port arbitration,
// one-cycle write stage and pending-write scoreboard. Option: ARMLEOCPU_REGFILE_BYPASS_EN.
module armleocpu_regfile_wb_ctrl
    import armleocpu_defines::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [REG_ADDR_W*NUM_REQ-1:0] req_rd_addr,
    input  logic [XLEN*NUM_REQ-1:0]      req_wdata,
    output logic [REG_ADDR_W-1:0]        rd_addr,
    output logic [XLEN-1:0]              rd_wdata,
    output logic                         rd_write,
    input  logic                         issue_valid,
    input  logic [REG_ADDR_W-1:0]        issue_rd_addr,
    input  logic [REG_ADDR_W-1:0]        rs1_addr,
    input  logic [REG_ADDR_W-1:0]        rs2_addr,
`ifdef ARMLEOCPU_REGFILE_BYPASS_EN
    input  logic [XLEN-1:0]              rf_rs1_rdata,
    input  logic [XLEN-1:0]              rf_rs2_rdata,
    output logic [XLEN-1:0]              rs1_rdata,
    output logic [XLEN-1:0]              rs2_rdata,
`endif
    output logic                         rs1_busy,
    output logic                         rs2_busy,
    output logic                         rd_busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]    grant_s;
    logic [IDX_W-1:0]      win_idx_s;
    logic                  transfer_s;
    logic [REG_ADDR_W-1:0] win_addr_s;
    logic [XLEN-1:0]       win_wdata_s;

    logic                  rd_write_q, rd_write_d;
    logic [REG_ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [XLEN-1:0]       rd_wdata_q, rd_wdata_d;
    logic [REG_COUNT-1:0]  pending_q, pending_d;

    logic                  clr_en_s;
    logic [REG_ADDR_W-1:0] clr_addr_s;

    armleocpu_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .accept    (transfer_s),
        .grant     (grant_s),
        .grant_idx (win_idx_s)
    );

    // The grant only ever goes to a valid requester, so any grant is a transfer.
    assign req_ready  = grant_s;
    assign transfer_s = |grant_s;

    // Winner payload mux.
    always_comb begin
        win_addr_s  = req_rd_addr[int'(win_idx_s)*REG_ADDR_W +: REG_ADDR_W];
        win_wdata_s = req_wdata[int'(win_idx_s)*XLEN +: XLEN];
    end

    // Write stage next-state: x0 writes are accepted but never reach the file.
    always_comb begin
        if (transfer_s) begin
            rd_write_d = (win_addr_s != {REG_ADDR_W{1'b0}});
            rd_addr_d  = win_addr_s;
            rd_wdata_d = win_wdata_s;
        end else begin
            rd_write_d = 1'b0;
            rd_addr_d  = rd_addr_q;
            rd_wdata_d = rd_wdata_q;
        end
    end

`ifdef ARMLEOCPU_REGFILE_BYPASS_EN
    // Early clear at acceptance; the forwarding path covers the commit cycle.
    always_comb begin
        clr_en_s   = transfer_s;
        clr_addr_s = win_addr_s;
    end

    // Forward the in-flight write over the register-file read data.
    always_comb begin
        if (rd_write_q && (rd_addr_q == rs1_addr) && (rs1_addr != {REG_ADDR_W{1'b0}})) begin
            rs1_rdata = rd_wdata_q;
        end else begin
            rs1_rdata = rf_rs1_rdata;
        end
        if (rd_write_q && (rd_addr_q == rs2_addr) && (rs2_addr != {REG_ADDR_W{1'b0}})) begin
            rs2_rdata = rd_wdata_q;
        end else begin
            rs2_rdata = rf_rs2_rdata;
        end
    end
`else
    // Clear on the edge the register file commits.
    always_comb begin
        clr_en_s   = rd_write_q;
        clr_addr_s = rd_addr_q;
    end
`endif

    // Scoreboard next-state: set is applied after clear so a new issue wins.
    always_comb begin
        pending_d = pending_q;
        if (clr_en_s) begin
            pending_d[clr_addr_s] = 1'b0;
        end else begin
            pending_d = pending_d;
        end
        if (issue_valid && (issue_rd_addr != {REG_ADDR_W{1'b0}})) begin
            pending_d[issue_rd_addr] = 1'b1;
        end else begin
            pending_d = pending_d;
        end
        pending_d[0] = 1'b0;
    end

    // Write stage and scoreboard registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_write_q <= 1'b0;
            rd_addr_q  <= {REG_ADDR_W{1'b0}};
            rd_wdata_q <= {XLEN{1'b0}};
            pending_q  <= {REG_COUNT{1'b0}};
        end else begin
            rd_write_q <= rd_write_d;
            rd_addr_q  <= rd_addr_d;
            rd_wdata_q <= rd_wdata_d;
            pending_q  <= pending_d;
        end
    end

    assign rd_write = rd_write_q;
    assign rd_addr  = rd_addr_q;
    assign rd_wdata = rd_wdata_q;

    assign rs1_busy = pending_q[rs1_addr];
    assign rs2_busy = pending_q[rs2_addr];
    assign rd_busy  = pending_q[issue_rd_addr];

endmodule
